// File: rtl/writeback_pkg.sv
// Shared types and decoded-opcode field helpers for the writeback stage.
// All widths and encodings come from core_general.vh; nothing is defined locally.
package writeback_pkg;

    `include "core_general.vh"

    localparam int unsigned USE_RD_W = USE_RD_BIT_M - USE_RD_BIT_L + 1;

    typedef logic [XLEN-1:0]     xlen_t;
    typedef logic [OPLEN-1:0]    op_t;
    typedef logic [USE_RD_W-1:0] use_rd_t;
    typedef logic [4:0]          reg_idx_t;

    // Extract the rd-data select field from a decoded opcode.
    function automatic use_rd_t use_rd_field(op_t op);
        return op[USE_RD_BIT_M:USE_RD_BIT_L];
    endfunction

    // Jump-enable flag of a decoded opcode.
    function automatic logic jump_enabled(op_t op);
        return op[JUMP_EN_BIT];
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Memory-to-writeback bundle plus the writeback results toward register file and fetch.
//   master : memory-stage side, drives the *_mw inputs and phase_writeback
//   slave  : writeback stage, drives rddata_wr, rdsel_wr, regdata_for_pc,
//            jump_state_wf and stall_writeback
interface writeback_if;
    import writeback_pkg::*;

    logic     phase_writeback;
    logic     jump_state_mw;
    op_t      decoded_op_mw;
    reg_idx_t rdsel_mw;
    xlen_t    next_pc_mw;
    xlen_t    alu_out_mw;
    xlen_t    mem_out_mw;

    xlen_t    rddata_wr;
    reg_idx_t rdsel_wr;
    xlen_t    regdata_for_pc;
    logic     jump_state_wf;
    logic     stall_writeback;

    modport master (
        output phase_writeback,
        output jump_state_mw,
        output decoded_op_mw,
        output rdsel_mw,
        output next_pc_mw,
        output alu_out_mw,
        output mem_out_mw,
        input  rddata_wr,
        input  rdsel_wr,
        input  regdata_for_pc,
        input  jump_state_wf,
        input  stall_writeback
    );

    modport slave (
        input  phase_writeback,
        input  jump_state_mw,
        input  decoded_op_mw,
        input  rdsel_mw,
        input  next_pc_mw,
        input  alu_out_mw,
        input  mem_out_mw,
        output rddata_wr,
        output rdsel_wr,
        output regdata_for_pc,
        output jump_state_wf,
        output stall_writeback
    );

endinterface

// File: rtl/core_general.vh
// Shared core-wide widths and decoded-opcode field layout.
// Included inside package and module scopes; holds only localparams, so it carries no guard
// and may be included in more than one scope of the same compilation unit.
//
//   XLEN          data and address width
//   OPLEN         decoded-opcode width
//   JUMP_EN_BIT   decoded-opcode bit that enables a taken jump
//   USE_RD_BIT_M  high bit of the rd-data select field
//   USE_RD_BIT_L  low bit of the rd-data select field
//   USE_RD_*      rd-data select encodings

localparam int unsigned XLEN         = 32;
localparam int unsigned OPLEN        = 9;

localparam int unsigned JUMP_EN_BIT  = 8;
localparam int unsigned USE_RD_BIT_M = 7;
localparam int unsigned USE_RD_BIT_L = 6;

localparam logic [1:0]  USE_RD_ALU    = 2'b00;
localparam logic [1:0]  USE_RD_PC     = 2'b01;
localparam logic [1:0]  USE_RD_MEMORY = 2'b10;
localparam logic [1:0]  USE_RD_COMP   = 2'b11;

// File: rtl/writeback_rd_data.sv
// 4:1 register-file write-data mux.
//   sel        rd-data select field of the decoded opcode
//   jump_state comparator result, zero-extended for the COMP source
//   alu_out    ALU result
//   next_pc    PC+4 of the retiring instruction
//   mem_out    data-memory load result
//   rd_data    selected write data; all-X when sel is not a known encoding
module writeback_rd_data
    import writeback_pkg::*;
(
    input  use_rd_t sel,
    input  logic    jump_state,
    input  xlen_t   alu_out,
    input  xlen_t   next_pc,
    input  xlen_t   mem_out,
    output xlen_t   rd_data
);

    // Plain case (not unique): an X/Z select must reach the default and propagate X
    // rather than being resolved to one of the legal sources.
    always_comb begin
        rd_data = 'x;
        case (sel)
            USE_RD_ALU:    rd_data = alu_out;
            USE_RD_PC:     rd_data = next_pc;
            USE_RD_MEMORY: rd_data = mem_out;
            USE_RD_COMP:   rd_data = {{(XLEN-1){1'b0}}, jump_state};
            default:       rd_data = 'x;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage of the five-phase core: picks the register-file write data, gates the
// destination index to the writeback phase and forwards jump state/target to fetch.
//   clk, rst : present for interface uniformity with the other stages; the datapath is
//              purely combinational and neither affects any output
//   wb       : writeback_if.slave, memory-stage inputs and writeback outputs
module writeback
    import writeback_pkg::*;
(
    input logic        clk,
    input logic        rst,
    writeback_if.slave wb
);

    use_rd_t use_rd_sel;
    xlen_t   rd_data;

    assign use_rd_sel = use_rd_field(wb.decoded_op_mw);

    writeback_rd_data u_rd_data (
        .sel        (use_rd_sel),
        .jump_state (wb.jump_state_mw),
        .alu_out    (wb.alu_out_mw),
        .next_pc    (wb.next_pc_mw),
        .mem_out    (wb.mem_out_mw),
        .rd_data    (rd_data)
    );

    assign wb.rddata_wr       = rd_data;
    // Outside the writeback phase steer the write to x0, which the register file ignores.
    assign wb.rdsel_wr        = wb.phase_writeback ? wb.rdsel_mw : 5'd0;
    assign wb.regdata_for_pc  = wb.alu_out_mw;
    assign wb.jump_state_wf   = wb.jump_state_mw & jump_enabled(wb.decoded_op_mw)
                                & wb.phase_writeback;
    // Writeback always completes within its phase.
    assign wb.stall_writeback = 1'b0;

    // clk/rst and the remaining opcode bits are intentionally unused in this revision.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, wb.decoded_op_mw[USE_RD_BIT_L-1:0]};

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for the writeback stage: the driver applies a vector each posedge and
// queues the expected outputs; the monitor pops and compares on each negedge.
module tb_writeback;

    `include "core_general.vh"

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    writeback_if bus ();

    writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    typedef struct {
        logic [XLEN-1:0] rddata;
        bit              want_x;
        logic [4:0]      rdsel;
        logic [XLEN-1:0] pc;
        logic            jump;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   four_state;
    logic probe;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [OPLEN-1:0] mk_op(input logic jen, input logic [1:0] sel);
        logic [OPLEN-1:0] op;
        op = '0;
        op[JUMP_EN_BIT] = jen;
        op[USE_RD_BIT_M:USE_RD_BIT_L] = sel;
        return op;
    endfunction

    // Reference: look the write data up in a table of sources keyed by the select encoding.
    function automatic exp_t model(input logic ph, input logic js, input logic [OPLEN-1:0] op,
                                   input logic [4:0] rs, input logic [XLEN-1:0] npc,
                                   input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                                   input bit want_x, input string name);
        exp_t            m;
        logic [XLEN-1:0] src [4];
        logic [1:0]      sel;
        src[USE_RD_ALU]    = alu;
        src[USE_RD_PC]     = npc;
        src[USE_RD_MEMORY] = mem;
        src[USE_RD_COMP]   = js ? XLEN'(1) : XLEN'(0);
        sel      = op[USE_RD_BIT_M:USE_RD_BIT_L];
        m.want_x = want_x;
        m.rddata = want_x ? '0 : src[sel];
        m.rdsel  = (ph == 1'b1) ? rs : 5'd0;
        m.pc     = alu;
        m.jump   = (ph == 1'b1 && js == 1'b1 && op[JUMP_EN_BIT] == 1'b1);
        m.name   = name;
        return m;
    endfunction

    task automatic drive(input bit r, input logic ph, input logic js,
                         input logic [OPLEN-1:0] op, input logic [4:0] rs,
                         input logic [XLEN-1:0] npc, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] mem, input bit want_x, input string name);
        @(posedge clk);
        rst                 = r;
        bus.phase_writeback = ph;
        bus.jump_state_mw   = js;
        bus.decoded_op_mw   = op;
        bus.rdsel_mw        = rs;
        bus.next_pc_mw      = npc;
        bus.alu_out_mw      = alu;
        bus.mem_out_mw      = mem;
        sb.push_back(model(ph, js, op, rs, npc, alu, mem, want_x, name));
    endtask

    // Monitor
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.want_x) begin
                    if (four_state) begin
                        checks++;
                        if (bus.rddata_wr !== {XLEN{1'bx}}) begin
                            errors++;
                            $display("FAIL %s/rddata: got %h, expected all-x", e.name,
                                     bus.rddata_wr);
                        end
                    end
                end else begin
                    check({e.name, "/rddata"}, bus.rddata_wr, e.rddata);
                end
                check({e.name, "/rdsel"}, XLEN'(bus.rdsel_wr), XLEN'(e.rdsel));
                check({e.name, "/pc"}, bus.regdata_for_pc, e.pc);
                check({e.name, "/jump"}, XLEN'(bus.jump_state_wf), XLEN'(e.jump));
                check({e.name, "/stall"}, XLEN'(bus.stall_writeback), XLEN'(0));
            end
        end
    end

    // Driver
    initial begin
        logic [OPLEN-1:0] xop;
        logic [XLEN-1:0]  pcv, aluv, memv;

        // Distinguish a 4-state simulator from a 2-state one for the X-propagation check.
        probe      = 1'bx;
        four_state = (probe !== 1'b0) && (probe !== 1'b1);

        rst                 = 1'b1;
        bus.phase_writeback = 1'b0;
        bus.jump_state_mw   = 1'b0;
        bus.decoded_op_mw   = '0;
        bus.rdsel_mw        = '0;
        bus.next_pc_mw      = '0;
        bus.alu_out_mw      = '0;
        bus.mem_out_mw      = '0;

        pcv  = 32'h1111_1111;
        aluv = 32'h2222_2222;
        memv = 32'hAAAA_AAAA;

        drive(1, 1, 1, mk_op(1, USE_RD_MEMORY), 5'd3, pcv, aluv, memv, 0, "reset_a");
        drive(1, 0, 1, mk_op(0, USE_RD_PC), 5'd9, pcv, aluv, memv, 0, "reset_b");
        drive(0, 1, 1, mk_op(0, USE_RD_ALU), 5'd1, pcv, aluv, memv, 0, "jump_off");
        drive(0, 1, 1, mk_op(1, USE_RD_ALU), 5'd1, pcv, aluv, memv, 0, "jump_on");
        drive(0, 1, 1, mk_op(0, USE_RD_ALU), 5'd2, pcv, aluv, memv, 0, "sel_alu");
        drive(0, 1, 1, mk_op(0, USE_RD_PC), 5'd2, pcv, aluv, memv, 0, "sel_pc");
        drive(0, 1, 1, mk_op(0, USE_RD_MEMORY), 5'd2, pcv, aluv, memv, 0, "sel_mem");
        drive(0, 1, 1, mk_op(0, USE_RD_COMP), 5'd2, pcv, aluv, memv, 0, "comp_one");
        drive(0, 1, 0, mk_op(0, USE_RD_COMP), 5'd2, pcv, aluv, memv, 0, "comp_zero");
        xop = mk_op(0, USE_RD_ALU);
        xop[USE_RD_BIT_M:USE_RD_BIT_L] = 2'bxx;
        drive(0, 1, 1, xop, 5'd2, pcv, aluv, memv, 1, "sel_x");
        drive(0, 1, 0, mk_op(0, USE_RD_ALU), 5'd4, pcv, 32'hAAAA_AAAA, memv, 0, "tgt_a");
        drive(0, 1, 0, mk_op(0, USE_RD_ALU), 5'd4, pcv, 32'h5555_5555, memv, 0, "tgt_5");
        drive(0, 1, 0, mk_op(0, USE_RD_PC), 5'd7, pcv, aluv, memv, 0, "rdsel_on");
        drive(0, 0, 0, mk_op(0, USE_RD_PC), 5'd7, pcv, aluv, memv, 0, "rdsel_off");
        drive(0, 0, 1, mk_op(1, USE_RD_COMP), 5'd7, pcv, aluv, memv, 0, "jump_nophase");

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
                  OPLEN'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 0, "random");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback.md
# writeback

Final stage of the RockWave five-phase core (fetch, decode, execute, memory, writeback). It selects the value written to the register file for the retiring instruction and forwards jump state and jump target to fetch. It sits between the memory stage (`*_mw` inputs) and the register file and fetch stage (`*_wr` and `*_wf` outputs). The datapath is purely combinational; clock and reset are present for interface uniformity with the other stage blocks.

## Interface
Parameters (from the shared `core_general.vh`):
- XLEN, 32: data and address width.
- OPLEN, 9: decoded-opcode width.

Ports:
- clk  in  1  core clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- phase_writeback  in  1  writeback phase is active.
- jump_state_mw  in  1  comparator/branch result from the memory stage.
- decoded_op_mw  in  OPLEN  decoded opcode.
- rdsel_mw  in  5  destination register index.
- next_pc_mw  in  XLEN  PC+4 of the retiring instruction.
- alu_out_mw  in  XLEN  ALU result.
- mem_out_mw  in  XLEN  data-memory load result.
- rddata_wr  out  XLEN  register-file write data.
- rdsel_wr  out  5  register-file write index.
- regdata_for_pc  out  XLEN  jump target for fetch.
- jump_state_wf  out  1  next PC is the jump target.
- stall_writeback  out  1  stall request to the state machine.

## Operation
- jump_state_wf = jump_state_mw AND decoded_op_mw[JUMP_EN_BIT] AND phase_writeback.
  - It is 0 whenever JUMP_EN_BIT is 0, regardless of jump_state_mw.
- rddata_wr is selected by the field decoded_op_mw[USE_RD_BIT_M:USE_RD_BIT_L]:
  - USE_RD_ALU selects alu_out_mw.
  - USE_RD_PC selects next_pc_mw.
  - USE_RD_MEMORY selects mem_out_mw.
  - USE_RD_COMP selects {31'b0, jump_state_mw} (zero-extended).
  - Any select value containing X or Z drives all-X. This uses a case default of 'bx; it must not fall through to a legal input.
- rdsel_wr:
  - equals rdsel_mw when phase_writeback = 1;
  - is 0 otherwise, because a write to x0 is a no-op in the register file.
- regdata_for_pc = alu_out_mw, unconditionally.
- stall_writeback is tied to 0; writeback always completes in its phase.

## Timing
- All outputs are combinational from the inputs with zero-cycle latency. There are no internal registers.
- clk has no functional use in this revision. It is kept so that a future registered variant does not change the interface.
- rst has no effect on any output. During reset, the outputs still follow their combinational equations, and stall_writeback = 0.
- The register file samples rddata_wr and rdsel_wr on its own clock edge while phase_writeback = 1. Inputs must be stable for the full phase.
- Simultaneous changes on the inputs settle within the same delta; there is no priority between them beyond the equations above.

## Structure
- `core_general.vh` is shared by all core stages and holds:
  - XLEN and OPLEN;
  - JUMP_EN_BIT;
  - USE_RD_BIT_M and USE_RD_BIT_L;
  - the four USE_RD_* encodings.
- This block defines no local encodings.
- One natural sub-module is `rd_data_sel`, the 4:1 rd-data mux with the X default. Inlining it as a case statement is also acceptable.
- The bench must include `core_general.vh` and must use the named constants, not literal encodings.

## Test plan
- Jump gating: with phase_writeback=1 and jump_state_mw=1:
  - JUMP_EN_BIT=0 → jump_state_wf=0;
  - set JUMP_EN_BIT=1 → jump_state_wf=1.
- Common setup for the rd-data mux: alu_out_mw=32'h2222_2222, next_pc_mw=32'h1111_1111, mem_out_mw=32'hAAAA_AAAA, jump_state_mw=1.
  - USE_RD_ALU → rddata_wr=32'h2222_2222.
  - USE_RD_PC → rddata_wr=32'h1111_1111.
  - USE_RD_MEMORY → rddata_wr=32'hAAAA_AAAA.
- COMP path:
  - USE_RD_COMP with jump_state_mw=1 → rddata_wr=32'h0000_0001;
  - with jump_state_mw=0 → rddata_wr=32'h0000_0000.
- Unknown select: USE_RD field = 2'bxx → rddata_wr === 32'hxxxx_xxxx. Check with case equality.
- Jump target:
  - alu_out_mw=32'hAAAA_AAAA → regdata_for_pc=32'hAAAA_AAAA;
  - alu_out_mw=32'h5555_5555 → regdata_for_pc=32'h5555_5555.
- rd index and stall:
  - rdsel_mw=5'd7 with phase_writeback=1 → rdsel_wr=7;
  - phase_writeback=0 → rdsel_wr=0;
  - stall_writeback=0 throughout, including while rst=1.
